// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of a single-ported data memory.
// Each accepted request runs IDLE -> ACCESS -> RESP and is held until the owner consumes it.
module dmem_arbiter #(
   parameter int unsigned MEM_WORDS = 64
) (
   input  logic        clk,
   input  logic        reset,

   input  logic        req_valid_0,
   output logic        req_ready_0,
   input  logic        req_we_0,
   input  logic [31:0] req_addr_0,
   input  logic [31:0] req_wdata_0,
   output logic        rsp_valid_0,
   input  logic        rsp_ready_0,
   output logic [31:0] rsp_rdata_0,
   output logic        rsp_err_0,

   input  logic        req_valid_1,
   output logic        req_ready_1,
   input  logic        req_we_1,
   input  logic [31:0] req_addr_1,
   input  logic [31:0] req_wdata_1,
   output logic        rsp_valid_1,
   input  logic        rsp_ready_1,
   output logic [31:0] rsp_rdata_1,
   output logic        rsp_err_1,

   output logic        mem_write,
   output logic [31:0] mem_address,
   output logic [31:0] mem_write_data,
   input  logic [31:0] mem_read_data,

   output logic        busy
);
   localparam int unsigned AW = 32;
   localparam logic [AW-1:0] MEM_LIMIT = AW'(MEM_WORDS);

   typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

   state_t        state;
   logic          last_grant;
   logic          owner;
   logic          we_q;
   logic          winner;
   logic          sel_we;
   logic [AW-1:0] sel_addr;
   logic [AW-1:0] sel_wdata;
   logic          acc_oor;
   logic [AW-1:0] acc_rdata;
   logic          rsp_taken;

   // Grant selection: a lone requester wins, a tie goes to the port not granted last.
   always_comb begin
      winner = 1'b0;
      if (req_valid_0 && req_valid_1) begin
         winner = ~last_grant;
      end else if (req_valid_1) begin
         winner = 1'b1;
      end
      req_ready_0 = (state == IDLE) && !reset && req_valid_0 && !winner;
      req_ready_1 = (state == IDLE) && !reset && req_valid_1 && winner;
      sel_we      = winner ? req_we_1    : req_we_0;
      sel_addr    = winner ? req_addr_1  : req_addr_0;
      sel_wdata   = winner ? req_wdata_1 : req_wdata_0;
      acc_oor     = !(mem_address < MEM_LIMIT);
      acc_rdata   = (!we_q && !acc_oor) ? mem_read_data : '0;
      rsp_taken   = owner ? rsp_ready_1 : rsp_ready_0;
   end

   assign busy = (state != IDLE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state          <= IDLE;
         last_grant     <= 1'b1;
         owner          <= 1'b0;
         we_q           <= 1'b0;
         mem_write      <= 1'b0;
         mem_address    <= '0;
         mem_write_data <= '0;
         rsp_valid_0    <= 1'b0;
         rsp_valid_1    <= 1'b0;
         rsp_rdata_0    <= '0;
         rsp_rdata_1    <= '0;
         rsp_err_0      <= 1'b0;
         rsp_err_1      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_ready_0 || req_ready_1) begin
                  owner          <= winner;
                  last_grant     <= winner;
                  we_q           <= sel_we;
                  mem_address    <= sel_addr;
                  mem_write_data <= sel_wdata;
                  mem_write      <= sel_we && (sel_addr < MEM_LIMIT);
                  state          <= ACCESS;
               end
            end
            ACCESS: begin
               // Capture the memory result for the owner only; the other port stays at zero.
               mem_write   <= 1'b0;
               rsp_valid_0 <= !owner;
               rsp_valid_1 <= owner;
               rsp_err_0   <= !owner && acc_oor;
               rsp_err_1   <= owner && acc_oor;
               rsp_rdata_0 <= owner ? '0 : acc_rdata;
               rsp_rdata_1 <= owner ? acc_rdata : '0;
               state       <= RESP;
            end
            RESP: begin
               if (rsp_taken) begin
                  rsp_valid_0 <= 1'b0;
                  rsp_valid_1 <= 1'b0;
                  rsp_err_0   <= 1'b0;
                  rsp_err_1   <= 1'b0;
                  rsp_rdata_0 <= '0;
                  rsp_rdata_1 <= '0;
                  state       <= IDLE;
               end
            end
            default: begin
               mem_write <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a 64-word memory model behind it.
// Inputs change just after negedge; outputs are sampled 1 time unit later.
module tb_dmem_arbiter;
   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid_0, req_ready_0, req_we_0;
   logic [31:0] req_addr_0, req_wdata_0;
   logic        rsp_valid_0, rsp_ready_0, rsp_err_0;
   logic [31:0] rsp_rdata_0;
   logic        req_valid_1, req_ready_1, req_we_1;
   logic [31:0] req_addr_1, req_wdata_1;
   logic        rsp_valid_1, rsp_ready_1, rsp_err_1;
   logic [31:0] rsp_rdata_1;
   logic        mem_write, busy;
   logic [31:0] mem_address, mem_write_data, mem_read_data;

   logic [31:0] ram [0:63];
   int          mw_count = 0;
   int          checks   = 0;
   int          failures = 0;

   dmem_arbiter #(.MEM_WORDS(64)) dut (
      .clk(clk), .reset(reset),
      .req_valid_0(req_valid_0), .req_ready_0(req_ready_0), .req_we_0(req_we_0),
      .req_addr_0(req_addr_0), .req_wdata_0(req_wdata_0),
      .rsp_valid_0(rsp_valid_0), .rsp_ready_0(rsp_ready_0),
      .rsp_rdata_0(rsp_rdata_0), .rsp_err_0(rsp_err_0),
      .req_valid_1(req_valid_1), .req_ready_1(req_ready_1), .req_we_1(req_we_1),
      .req_addr_1(req_addr_1), .req_wdata_1(req_wdata_1),
      .rsp_valid_1(rsp_valid_1), .rsp_ready_1(rsp_ready_1),
      .rsp_rdata_1(rsp_rdata_1), .rsp_err_1(rsp_err_1),
      .mem_write(mem_write), .mem_address(mem_address),
      .mem_write_data(mem_write_data), .mem_read_data(mem_read_data),
      .busy(busy)
   );

   always #5 clk = ~clk;

   // Memory model; out-of-range reads return a marker so leaked data is visible.
   always_comb begin
      if (mem_address < 32'd64) mem_read_data = ram[mem_address[5:0]];
      else                      mem_read_data = 32'hBAD0_BAD0;
   end

   always @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 64; i++) ram[i] <= 32'h0;
         ram[5]  <= 32'hDEAD_BEEF;
         ram[63] <= 32'hCAFE_F00D;
      end else if (mem_write) begin
         if (mem_address < 32'd64) ram[mem_address[5:0]] <= mem_write_data;
         mw_count <= mw_count + 1;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic check1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic port, input logic v, input logic we,
                        input logic [31:0] addr, input logic [31:0] wdata);
      if (port) begin
         req_valid_1 = v; req_we_1 = we; req_addr_1 = addr; req_wdata_1 = wdata;
      end else begin
         req_valid_0 = v; req_we_0 = we; req_addr_0 = addr; req_wdata_0 = wdata;
      end
   endtask

   // One uncontended access with rsp_ready held high: handshake, ACCESS, RESP, back to IDLE.
   task automatic run_access(input string tag, input logic port, input logic we,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [31:0] exp_rdata, input logic exp_err, input logic exp_mw);
      int base;
      @(negedge clk);
      drive(port, 1'b1, we, addr, wdata);
      rsp_ready_0 = 1'b1;
      rsp_ready_1 = 1'b1;
      #1;
      base = mw_count;
      check1({tag, "_ready"}, port ? req_ready_1 : req_ready_0, 1'b1);
      check1({tag, "_ready_other"}, port ? req_ready_0 : req_ready_1, 1'b0);
      @(negedge clk);
      drive(port, 1'b0, 1'b0, 32'h0, 32'h0);
      #1;
      check1({tag, "_busy_access"}, busy, 1'b1);
      check1({tag, "_mem_write"}, mem_write, exp_mw);
      check32({tag, "_mem_address"}, mem_address, addr);
      check32({tag, "_mem_wdata"}, mem_write_data, wdata);
      @(negedge clk);
      #1;
      check1({tag, "_rsp_valid"}, port ? rsp_valid_1 : rsp_valid_0, 1'b1);
      check1({tag, "_rsp_valid_other"}, port ? rsp_valid_0 : rsp_valid_1, 1'b0);
      check32({tag, "_rdata"}, port ? rsp_rdata_1 : rsp_rdata_0, exp_rdata);
      check1({tag, "_err"}, port ? rsp_err_1 : rsp_err_0, exp_err);
      check32({tag, "_rdata_other"}, port ? rsp_rdata_0 : rsp_rdata_1, 32'h0);
      check1({tag, "_mem_write_resp"}, mem_write, 1'b0);
      @(negedge clk);
      #1;
      check1({tag, "_idle"}, busy, 1'b0);
      check1({tag, "_rsp_done"}, port ? rsp_valid_1 : rsp_valid_0, 1'b0);
      check32({tag, "_write_count"}, 32'(mw_count - base), {31'h0, exp_mw});
   endtask

   task automatic pulse_reset;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      int base;
      reset = 1'b1;
      drive(1'b0, 1'b1, 1'b0, 32'd5, 32'h0);
      drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      rsp_ready_0 = 1'b0;
      rsp_ready_1 = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      check1("rst_ready_0", req_ready_0, 1'b0);
      check1("rst_rsp_valid_0", rsp_valid_0, 1'b0);
      check1("rst_mem_write", mem_write, 1'b0);
      check32("rst_mem_address", mem_address, 32'h0);
      check32("rst_mem_wdata", mem_write_data, 32'h0);
      check32("rst_rdata_0", rsp_rdata_0, 32'h0);
      check1("rst_busy", busy, 1'b0);
      @(negedge clk);
      reset = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      #1;
      check1("idle_no_req_ready_0", req_ready_0, 1'b0);
      check1("idle_no_req_ready_1", req_ready_1, 1'b0);

      run_access("rd5",     1'b0, 1'b0, 32'd5,         32'h0,         32'hDEAD_BEEF, 1'b0, 1'b0);
      run_access("wr10",    1'b1, 1'b1, 32'd10,        32'h1234_5678, 32'h0,         1'b0, 1'b1);
      run_access("rd10",    1'b1, 1'b0, 32'd10,        32'h0,         32'h1234_5678, 1'b0, 1'b0);
      run_access("wr64",    1'b0, 1'b1, 32'd64,        32'hAAAA_5555, 32'h0,         1'b1, 1'b0);
      run_access("wrffff",  1'b0, 1'b1, 32'hFFFF_FFFF, 32'h5555_AAAA, 32'h0,         1'b1, 1'b0);
      run_access("rd64",    1'b1, 1'b0, 32'd64,        32'h0,         32'h0,         1'b1, 1'b0);
      run_access("rd63",    1'b0, 1'b0, 32'd63,        32'h0,         32'hCAFE_F00D, 1'b0, 1'b0);

      // Both ports request continuously: grants at cycles 0,3,6,9 alternating 0,1,0,1.
      pulse_reset();
      drive(1'b0, 1'b1, 1'b0, 32'd5, 32'h0);
      drive(1'b1, 1'b1, 1'b0, 32'd63, 32'h0);
      rsp_ready_0 = 1'b1;
      rsp_ready_1 = 1'b1;
      for (int i = 0; i < 12; i++) begin
         #1;
         check1($sformatf("rr_ready0_c%0d", i), req_ready_0, (i % 6) == 0);
         check1($sformatf("rr_ready1_c%0d", i), req_ready_1, (i % 6) == 3);
         @(negedge clk);
      end
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      repeat (3) @(negedge clk);

      // Port 0 response held back for 4 cycles while port 1 waits.
      pulse_reset();
      drive(1'b0, 1'b1, 1'b0, 32'd5, 32'h0);
      drive(1'b1, 1'b1, 1'b0, 32'd63, 32'h0);
      rsp_ready_0 = 1'b0;
      rsp_ready_1 = 1'b1;
      #1;
      check1("bp_grant0", req_ready_0, 1'b1);
      check1("bp_hold1", req_ready_1, 1'b0);
      @(negedge clk);
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      #1;
      check1("bp_access_ready1", req_ready_1, 1'b0);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         #1;
         check1($sformatf("bp_valid_%0d", k), rsp_valid_0, 1'b1);
         check32($sformatf("bp_rdata_%0d", k), rsp_rdata_0, 32'hDEAD_BEEF);
         check1($sformatf("bp_busy_%0d", k), busy, 1'b1);
         check1($sformatf("bp_ready1_%0d", k), req_ready_1, 1'b0);
      end
      @(negedge clk);
      rsp_ready_0 = 1'b1;
      #1;
      check1("bp_rise_valid", rsp_valid_0, 1'b1);
      check1("bp_rise_ready1", req_ready_1, 1'b0);
      @(negedge clk);
      #1;
      check1("bp_after_ready1", req_ready_1, 1'b1);
      check1("bp_after_valid0", rsp_valid_0, 1'b0);
      @(negedge clk);
      drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
      #1;
      check1("bp_p1_valid", rsp_valid_1, 1'b1);
      check32("bp_p1_rdata", rsp_rdata_1, 32'hCAFE_F00D);
      check32("bp_p0_rdata_zero", rsp_rdata_0, 32'h0);
      @(negedge clk);

      // Reset while a response is pending.
      drive(1'b0, 1'b1, 1'b0, 32'd5, 32'h0);
      rsp_ready_0 = 1'b0;
      @(negedge clk);
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
      #1;
      check1("rr_resp_valid", rsp_valid_0, 1'b1);
      reset = 1'b1;
      #1;
      check1("rr_resp_drop", rsp_valid_0, 1'b0);
      check32("rr_resp_rdata", rsp_rdata_0, 32'h0);
      check1("rr_resp_busy", busy, 1'b0);
      @(negedge clk);
      reset = 1'b0;
      rsp_ready_0 = 1'b1;

      // Reset while a write is in ACCESS: no memory write may follow.
      drive(1'b1, 1'b1, 1'b1, 32'd20, 32'h0000_0055);
      #1;
      base = mw_count;
      @(negedge clk);
      drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      #1;
      check1("ra_mem_write_pre", mem_write, 1'b1);
      reset = 1'b1;
      #1;
      check1("ra_mem_write_drop", mem_write, 1'b0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check32("ra_no_write", 32'(mw_count - base), 32'h0);

      // After reset, a tie is granted to port 0.
      drive(1'b0, 1'b1, 1'b0, 32'd5, 32'h0);
      drive(1'b1, 1'b1, 1'b0, 32'd63, 32'h0);
      #1;
      check1("post_rst_tie0", req_ready_0, 1'b1);
      check1("post_rst_tie1", req_ready_1, 1'b0);
      @(negedge clk);
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      repeat (3) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter MEM_WORDS, default 64, number of 32-bit words in the data memory; valid word addresses are 0..MEM_WORDS-1.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req_valid_0 / req_valid_1  input  1  requester n presents an access.
REQ-005 req_ready_0 / req_ready_1  output  1  arbiter accepts requester n this cycle.
REQ-006 req_we_0 / req_we_1  input  1  1 = write, 0 = read.
REQ-007 req_addr_0 / req_addr_1  input  32  word address (not byte address).
REQ-008 req_wdata_0 / req_wdata_1  input  32  write data.
REQ-009 rsp_valid_0 / rsp_valid_1  output  1  response for requester n is available.
REQ-010 rsp_ready_0 / rsp_ready_1  input  1  requester n consumes the response.
REQ-011 rsp_rdata_0 / rsp_rdata_1  output  32  read data; 0 for writes and errors.
REQ-012 rsp_err_0 / rsp_err_1  output  1  address was out of range.
REQ-013 mem_write  output  1  write enable to the data memory.
REQ-014 mem_address  output  32  word address to the data memory.
REQ-015 mem_write_data  output  32  write data to the data memory.
REQ-016 mem_read_data  input  32  combinational read data from the data memory.
REQ-017 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-018 The FSM SHALL have three states: IDLE, ACCESS and RESP.
REQ-019 In IDLE, if no req_valid is high, the FSM SHALL stay in IDLE with both req_ready low.
REQ-020 In IDLE with exactly one req_valid high, that port SHALL be the winner.
REQ-021 In IDLE with both req_valid high, the winner SHALL be the port not recorded in last_grant (round-robin).
REQ-022 The winner's req_ready SHALL be asserted combinationally in IDLE; the other port's req_ready SHALL be low.
REQ-023 On the handshake (req_valid & req_ready), the block SHALL latch we, addr, wdata and the owner id; set last_grant to the owner; and go to ACCESS.
REQ-024 ACCESS SHALL last exactly one cycle and then go to RESP.
REQ-025 In ACCESS, mem_write SHALL equal latched we AND (latched addr < MEM_WORDS).
REQ-026 mem_write SHALL be low in every other state, and SHALL be asserted at most once per accepted request.
REQ-027 mem_address and mem_write_data SHALL always drive the latched addr and wdata registers.
REQ-028 At the end of ACCESS, the block SHALL register the response:
  - rdata = mem_read_data for an in-range read, otherwise 0;
  - err = (addr >= MEM_WORDS), compared as a full 32-bit unsigned value.
REQ-029 In RESP, rsp_valid SHALL be high for the owner only; rdata and err SHALL remain stable until consumed.
REQ-030 In RESP, when the owner's rsp_ready is high, the FSM SHALL return to IDLE on that edge.
REQ-031 req_ready SHALL be low in ACCESS and RESP; a new request is only accepted in IDLE, the cycle after the handshake at the earliest.
REQ-032 Minimum latency SHALL be:
  - handshake cycle to rsp_valid: 2 cycles;
  - throughput: one access per 3 cycles when rsp_ready is held high.
REQ-033 rsp_rdata and rsp_err for a non-owner port SHALL be 0.
REQ-034 req_valid changing during ACCESS or RESP SHALL have no effect; requesters hold their request until ready.

Reset
REQ-035 While reset is high, the block SHALL force:
  - FSM = IDLE; last_grant = 1 (port 0 wins the first tie);
  - all req_ready, rsp_valid, rsp_err and mem_write low;
  - rsp_rdata = 0, mem_address = 0, mem_write_data = 0.
REQ-036 A reset asserted during ACCESS or RESP SHALL abort the access: no write occurs after reset assertion and the pending response is discarded.

Verification
REQ-037 Single read: RAM[5]=0xDEADBEEF; port 0 reads addr 5, rsp_ready=1 → ready_0 in cycle 0, rsp_valid_0 in cycle 2 with rdata 0xDEADBEEF, err 0.
REQ-038 Write then read: port 1 writes 0x12345678 to addr 10 → mem_write high exactly one cycle; a following port 1 read of addr 10 returns 0x12345678.
REQ-039 Contention: both ports hold valid continuously after reset → grants alternate 0,1,0,1; each grant is 3 cycles apart.
REQ-040 Out of range: port 0 writes addr 64 → mem_write never high, rsp_err_0=1, rdata 0; with addr 0xFFFFFFFF → same response.
REQ-041 Backpressure: rsp_ready_0 held low for 4 cycles → rsp_valid_0 and rdata stay stable; busy stays 1; port 1 request not accepted until the cycle after rsp_ready_0 rises.
REQ-042 Reset during RESP: assert reset → rsp_valid drops immediately; after release, a simultaneous request from both ports is granted to port 0 first.
